// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: sequences the shared Mult/Div units, operand muxes, temp register and Hi/Lo writes
module mult_div_ctrl #(
   parameter int MEM_LAT = 1,
   parameter int TIMEOUT = 40
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [1:0] op,
   input  logic       mult_done,
   input  logic [1:0] div_status,
   output logic [1:0] Mult,
   output logic [1:0] Div,
   output logic       DivMultEntry,
   output logic       DivMultTempWrite,
   output logic       MDWrite,
   output logic [2:0] MemAdrsSrc,
   output logic       DivorMult,
   output logic       WriteHi,
   output logic       WriteLo,
   output logic       busy,
   output logic       done,
   output logic       div0,
   output logic       err
);
   typedef enum logic [3:0] {IDLE, RD_B, LD_B, TMP, RD_A, LD_A, START, WAIT, WRITE, FIN, EXC} state_t;
   localparam logic [1:0] OP_MULT = 2'b00, OP_DIVM = 2'b10, OP_ILL = 2'b11;
   localparam logic [1:0] C_ILL = 2'd0, C_TO = 2'd1, C_DIV0 = 2'd2;
   localparam logic [7:0] LAT = 8'(MEM_LAT - 1);
   localparam logic [7:0] TO = 8'(TIMEOUT);
   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] op_q, op_d;
   logic [1:0] cause_q, cause_d;
   logic       is_mult, is_divm, clr;
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= OP_MULT;
         cause_q <= C_ILL;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         cause_q <= cause_d;
      end
   end
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cause_d = cause_q;
      case (state_q)
         IDLE:
            if (start) begin
               op_d    = op;
               cause_d = C_ILL;
               state_d = op == OP_ILL ? EXC : op == OP_DIVM ? RD_B : START;
            end
         RD_B:  state_d = cnt_q == LAT ? LD_B : RD_B;
         LD_B:  state_d = TMP;
         TMP:   state_d = RD_A;
         RD_A:  state_d = cnt_q == LAT ? LD_A : RD_A;
         LD_A:  state_d = START;
         START: state_d = WAIT;
         WAIT:
            // div0 outranks a same-cycle completion; completion outranks timeout
            if (op_q != OP_MULT && div_status[1]) begin
               state_d = EXC;
               cause_d = C_DIV0;
            end else if (op_q == OP_MULT ? mult_done : div_status[0]) begin
               state_d = WRITE;
            end else if (cnt_q == TO) begin
               state_d = EXC;
               cause_d = C_TO;
            end
         WRITE:   state_d = FIN;
         FIN:     state_d = IDLE;
         EXC:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 8'd1;
   end
   always_comb begin
      is_mult          = op_q == OP_MULT;
      is_divm          = op_q == OP_DIVM;
      clr              = state_q == EXC && cause_q != C_ILL;
      Mult             = (state_q == START && is_mult) ? 2'b01 : (clr && is_mult) ? 2'b11 : 2'b00;
      Div              = (state_q == START && !is_mult) ? 2'b01 : (clr && !is_mult) ? 2'b11 : 2'b00;
      DivMultEntry     = is_divm && state_q inside {START, WAIT, WRITE};
      DivMultTempWrite = state_q == TMP;
      MDWrite          = state_q inside {LD_B, LD_A};
      MemAdrsSrc       = state_q inside {RD_B, LD_B} ? 3'b011 : state_q inside {RD_A, LD_A} ? 3'b010 : 3'b000;
      DivorMult        = is_mult && state_q inside {WAIT, WRITE};
      WriteHi          = state_q == WRITE;
      WriteLo          = state_q == WRITE;
      busy             = state_q != IDLE;
      done             = state_q == FIN;
      div0             = state_q == EXC && cause_q == C_DIV0;
      err              = state_q == EXC && cause_q != C_DIV0;
   end
endmodule

// File: tb/tb_mult_div_ctrl.sv
// tb_mult_div_ctrl: table-driven cycle-by-cycle check of every mult_div_ctrl output
module tb_mult_div_ctrl;
   logic       clk = 1'b0;
   logic       reset = 1'b1, start = 1'b0, mult_done = 1'b0;
   logic [1:0] op = 2'b00, div_status = 2'b00;
   logic [1:0] Mult, Div;
   logic       DivMultEntry, DivMultTempWrite, MDWrite, DivorMult, WriteHi, WriteLo;
   logic       busy, done, div0, err;
   logic [2:0] MemAdrsSrc;
   logic [16:0] act;
   int checks = 0, errors = 0;

   localparam logic [16:0] M_ST = 17'h08000, M_CLR = 17'h18000, D_ST = 17'h02000, D_CLR = 17'h06000;
   localparam logic [16:0] ENT = 17'h01000, TW = 17'h00800, MDW = 17'h00400;
   localparam logic [16:0] ADR_B = 17'h00180, ADR_A = 17'h00100, DM = 17'h00040, WHL = 17'h00030;
   localparam logic [16:0] BSY = 17'h00008, DN = 17'h00004, D0 = 17'h00002, ER = 17'h00001;

   typedef struct {
      string       nm;
      int          n;
      logic        rst;
      logic        st;
      logic [1:0]  op;
      logic        md;
      logic [1:0]  ds;
      logic [16:0] exp;
   } vec_t;
   vec_t vq[$];

   mult_div_ctrl #(.MEM_LAT(1), .TIMEOUT(40)) dut (
      .clock(clk), .reset(reset), .start(start), .op(op), .mult_done(mult_done),
      .div_status(div_status), .Mult(Mult), .Div(Div), .DivMultEntry(DivMultEntry),
      .DivMultTempWrite(DivMultTempWrite), .MDWrite(MDWrite), .MemAdrsSrc(MemAdrsSrc),
      .DivorMult(DivorMult), .WriteHi(WriteHi), .WriteLo(WriteLo), .busy(busy),
      .done(done), .div0(div0), .err(err));

   always #5 clk = ~clk;

   assign act = {Mult, Div, DivMultEntry, DivMultTempWrite, MDWrite, MemAdrsSrc,
                 DivorMult, WriteHi, WriteLo, busy, done, div0, err};

   function automatic vec_t mk(string nm, int n, logic rst, logic st, logic [1:0] o,
                               logic md, logic [1:0] ds, logic [16:0] e);
      vec_t r;
      r.nm = nm; r.n = n; r.rst = rst; r.st = st; r.op = o; r.md = md; r.ds = ds; r.exp = e;
      return r;
   endfunction

   function automatic void add(string nm, int n, logic st, logic [1:0] o, logic md,
                               logic [1:0] ds, logic [16:0] e);
      vq.push_back(mk(nm, n, 1'b0, st, o, md, ds, e));
   endfunction

   task automatic apply(input vec_t r);
      for (int k = 0; k < r.n; k++) begin
         @(negedge clk);
         reset = r.rst; start = r.st; op = r.op; mult_done = r.md; div_status = r.ds;
         checks++;
         if (act !== r.exp) begin
            errors++;
            $display("FAIL %s cycle+%0d outputs %h expected %h", r.nm, k, act, r.exp);
         end
      end
   endtask

   initial begin
      // mult: stray completion in START, div_status and start during WAIT all ignored
      add("m_idle", 1, 0, 2'd0, 0, 2'b00, 17'h0);
      add("m_req", 1, 1, 2'd0, 0, 2'b00, 17'h0);
      add("m_start", 1, 0, 2'd0, 1, 2'b00, M_ST | BSY);
      add("m_wait_ds", 1, 0, 2'd0, 0, 2'b11, BSY | DM);
      add("m_wait_st", 1, 1, 2'd1, 0, 2'b00, BSY | DM);
      add("m_wait", 1, 0, 2'd0, 0, 2'b00, BSY | DM);
      add("m_cmpl", 1, 0, 2'd0, 1, 2'b00, BSY | DM);
      add("m_write", 1, 0, 2'd0, 0, 2'b00, BSY | DM | WHL);
      add("m_fin", 1, 0, 2'd0, 0, 2'b00, BSY | DN);
      add("m_noqueue", 2, 0, 2'd0, 0, 2'b00, 17'h0);
      // div, completion at cycle 9
      add("d_req", 1, 1, 2'd1, 0, 2'b00, 17'h0);
      add("d_start", 1, 0, 2'd0, 0, 2'b00, D_ST | BSY);
      add("d_wait", 7, 0, 2'd0, 1, 2'b00, BSY);
      add("d_cmpl", 1, 0, 2'd0, 0, 2'b01, BSY);
      add("d_write", 1, 0, 2'd0, 0, 2'b00, BSY | WHL);
      add("d_fin", 1, 0, 2'd0, 0, 2'b00, BSY | DN);
      add("d_idle", 1, 0, 2'd0, 0, 2'b00, 17'h0);
      // divm operand fetch with MEM_LAT=1
      add("dm_req", 1, 1, 2'd2, 0, 2'b00, 17'h0);
      add("dm_rd_b", 1, 0, 2'd0, 0, 2'b01, BSY | ADR_B);
      add("dm_ld_b", 1, 0, 2'd0, 0, 2'b00, BSY | ADR_B | MDW);
      add("dm_tmp", 1, 0, 2'd0, 0, 2'b00, BSY | TW);
      add("dm_rd_a", 1, 0, 2'd0, 0, 2'b00, BSY | ADR_A);
      add("dm_ld_a", 1, 0, 2'd0, 0, 2'b00, BSY | ADR_A | MDW);
      add("dm_start", 1, 0, 2'd0, 0, 2'b00, BSY | D_ST | ENT);
      add("dm_wait", 2, 0, 2'd0, 0, 2'b00, BSY | ENT);
      add("dm_cmpl", 1, 0, 2'd0, 0, 2'b01, BSY | ENT);
      add("dm_write", 1, 0, 2'd0, 0, 2'b00, BSY | ENT | WHL);
      add("dm_fin", 1, 0, 2'd0, 0, 2'b00, BSY | DN);
      add("dm_idle", 1, 0, 2'd0, 0, 2'b00, 17'h0);
      // divide by zero, both status bits together
      add("z_req", 1, 1, 2'd1, 0, 2'b00, 17'h0);
      add("z_start", 1, 0, 2'd0, 0, 2'b00, D_ST | BSY);
      add("z_wait", 2, 0, 2'd0, 0, 2'b00, BSY);
      add("z_status", 1, 0, 2'd0, 0, 2'b11, BSY);
      add("z_exc", 1, 0, 2'd0, 0, 2'b00, BSY | D_CLR | D0);
      add("z_idle", 1, 0, 2'd0, 0, 2'b00, 17'h0);
      // illegal op
      add("i_req", 1, 1, 2'd3, 0, 2'b00, 17'h0);
      add("i_exc", 1, 0, 2'd0, 0, 2'b00, BSY | ER);
      add("i_idle", 1, 0, 2'd0, 0, 2'b00, 17'h0);
      // completion exactly when the counter reaches TIMEOUT
      add("l_req", 1, 1, 2'd0, 0, 2'b00, 17'h0);
      add("l_start", 1, 0, 2'd0, 0, 2'b00, M_ST | BSY);
      add("l_wait", 40, 0, 2'd0, 0, 2'b00, BSY | DM);
      add("l_cmpl", 1, 0, 2'd0, 1, 2'b00, BSY | DM);
      add("l_write", 1, 0, 2'd0, 0, 2'b00, BSY | DM | WHL);
      add("l_fin", 1, 0, 2'd0, 0, 2'b00, BSY | DN);
      add("l_idle", 1, 0, 2'd0, 0, 2'b00, 17'h0);
      // mult timeout, err and clear at cycle 43
      add("t_req", 1, 1, 2'd0, 0, 2'b00, 17'h0);
      add("t_start", 1, 0, 2'd0, 0, 2'b00, M_ST | BSY);
      add("t_wait", 41, 0, 2'd0, 0, 2'b00, BSY | DM);
      add("t_exc", 1, 0, 2'd0, 0, 2'b00, BSY | M_CLR | ER);
      add("t_idle", 1, 0, 2'd0, 0, 2'b00, 17'h0);

      repeat (2) @(posedge clk);
      apply(mk("reset", 1, 1, 0, 2'd0, 0, 2'b00, 17'h0));
      for (int i = 0; i < vq.size(); i++) apply(vq[i]);

      // reset during WAIT aborts silently, then a fresh mult completes
      apply(mk("r_req", 1, 0, 1, 2'd0, 0, 2'b00, 17'h0));
      apply(mk("r_start", 1, 0, 0, 2'd0, 0, 2'b00, M_ST | BSY));
      apply(mk("r_wait", 1, 0, 0, 2'd0, 0, 2'b00, BSY | DM));
      apply(mk("r_assert", 1, 1, 0, 2'd0, 0, 2'b00, BSY | DM));
      apply(mk("r_after", 1, 0, 1, 2'd0, 0, 2'b00, 17'h0));
      apply(mk("r2_start", 1, 0, 0, 2'd0, 0, 2'b00, M_ST | BSY));
      apply(mk("r2_cmpl", 1, 0, 0, 2'd0, 1, 2'b00, BSY | DM));
      apply(mk("r2_write", 1, 0, 0, 2'd0, 0, 2'b00, BSY | DM | WHL));
      apply(mk("r2_fin", 1, 0, 0, 2'd0, 0, 2'b00, BSY | DN));
      apply(mk("r2_idle", 1, 0, 0, 2'd0, 0, 2'b00, 17'h0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
